// File: rtl/sound_reg_ctrl.sv
// CPU register front-end for the SN76477 sound generator: shadow A/B/C, atomic commit on B, mute/apply/release sequencing.
// Optional registered readback port enabled by defining SOUND_CTRL_READBACK_EN.
module sound_reg_ctrl #(
   parameter int MUTE_CYCLES = 256,
   parameter int MUTE_W      = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [1:0] attack,
   output logic [1:0] decay,
   output logic [1:0] slf_sel,
   output logic       vco_pitch,
   output logic       noise_filt,
   output logic [2:0] mixer_ctl,
   output logic [1:0] envsel,
   output logic       vco_sel,
   output logic       volume_half,
   output logic       inhibit_o,
   output logic       oneshot_decay,
   output logic       vco_ext,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, MUTE = 2'd1, APPLY = 2'd2, RELEASE = 2'd3} state_t;

   state_t            state, state_d;
   logic [MUTE_W-1:0] cnt, cnt_d;
   logic              pend, pend_d;
   logic              inh, inh_d;
   logic [7:0]        sh_a, sh_b;
   logic [1:0]        sh_c;
   logic [7:0]        act_a, act_b;
   logic [1:0]        act_c;
   logic              commit;
   logic [7:0]        commit_b;
   logic              load_act;
   logic [7:0]        ld_b;

   // A commit takes B straight from the bus so an inhibited commit lands on the same edge.
   assign commit   = wr_en && (wr_addr == 2'd1);
   assign commit_b = commit ? wr_data : sh_b;

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      pend_d   = pend;
      inh_d    = inh;
      load_act = 1'b0;
      ld_b     = sh_b;
      case (state)
         IDLE: begin
            if (commit || pend) begin
               pend_d = 1'b0;
               inh_d  = 1'b1;
               if (commit_b[7]) begin
                  load_act = 1'b1;
                  ld_b     = commit_b;
               end else begin
                  cnt_d   = MUTE_W'(MUTE_CYCLES - 1);
                  state_d = MUTE;
               end
            end
         end
         MUTE: begin
            if (cnt == '0) state_d = APPLY;
            else           cnt_d   = cnt - MUTE_W'(1);
            if (commit)    pend_d  = 1'b1;
         end
         APPLY: begin
            load_act = 1'b1;
            state_d  = RELEASE;
            if (commit) pend_d = 1'b1;
         end
         RELEASE: begin
            inh_d   = 1'b0;
            state_d = IDLE;
            if (commit) pend_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
         inh   <= 1'b1;
         sh_a  <= 8'h00;
         sh_b  <= 8'h00;
         sh_c  <= 2'b00;
         act_a <= 8'h00;
         act_b <= 8'h80;
         act_c <= 2'b00;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         pend  <= pend_d;
         inh   <= inh_d;
         if (wr_en) begin
            case (wr_addr)
               2'd0:    sh_a <= wr_data;
               2'd1:    sh_b <= wr_data;
               2'd2:    sh_c <= wr_data[1:0];
               default: ;
            endcase
         end
         if (load_act) begin
            act_a <= sh_a;
            act_b <= ld_b;
            act_c <= sh_c;
         end
      end
   end

   assign busy          = (state != IDLE) | pend;
   assign inhibit_o     = inh;
   assign attack        = act_a[1:0];
   assign decay         = act_a[3:2];
   assign slf_sel       = act_a[5:4];
   assign vco_pitch     = act_a[6];
   assign noise_filt    = act_a[7];
   assign mixer_ctl     = act_b[2:0];
   assign envsel        = act_b[4:3];
   assign vco_sel       = act_b[5];
   assign volume_half   = act_b[6];
   assign oneshot_decay = act_c[0];
   assign vco_ext       = act_c[1];

`ifdef SOUND_CTRL_READBACK_EN
   logic [7:0] rd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= 8'h00;
      end else begin
         case (rd_addr)
            2'd0:    rd_q <= act_a;
            2'd1:    rd_q <= act_b;
            2'd2:    rd_q <= {6'b0, act_c};
            default: rd_q <= {busy, pend, state, 3'b000, inh};
         endcase
      end
   end

   assign rd_data = rd_q;
`else
   logic unused_rd;

   assign rd_data   = 8'h00;
   assign unused_rd = ^{rd_addr, act_b[7]};
`endif

endmodule

// File: tb/tb_sound_reg_ctrl.sv
// Scoreboard bench for sound_reg_ctrl: stimulus queues expected output snapshots per cycle, a monitor checks them and flags any unscheduled output change.
module tb_sound_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic [1:0] attack, decay, slf_sel, envsel;
   logic       vco_pitch, noise_filt, vco_sel, volume_half;
   logic       inhibit_o, oneshot_decay, vco_ext, busy;
   logic [2:0] mixer_ctl;

   sound_reg_ctrl #(.MUTE_CYCLES(256), .MUTE_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .attack(attack), .decay(decay),
      .slf_sel(slf_sel), .vco_pitch(vco_pitch), .noise_filt(noise_filt),
      .mixer_ctl(mixer_ctl), .envsel(envsel), .vco_sel(vco_sel),
      .volume_half(volume_half), .inhibit_o(inhibit_o), .oneshot_decay(oneshot_decay),
      .vco_ext(vco_ext), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       inh;
      logic       busy;
      logic       osd;
      logic       vext;
      logic       vhalf;
      logic       vsel;
      logic [1:0] env;
      logic [2:0] mix;
      logic       nf;
      logic       vp;
      logic [1:0] slf;
      logic [1:0] dec;
      logic [1:0] att;
   } ov_t;

   typedef struct {
      int  cyc;
      ov_t v;
   } ent_t;

   ov_t  ov, m, prev;
   ent_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;

   assign ov = {inhibit_o, busy, oneshot_decay, vco_ext, volume_half, vco_sel, envsel,
                mixer_ctl, noise_filt, vco_pitch, slf_sel, decay, attack};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ent_t e;
            e = exp_q.pop_front();
            total++;
            if (ov !== e.v) begin
               bad++;
               $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, ov, e.v);
            end
         end else if (ov !== prev) begin
            total++;
            bad++;
            $display("FAIL unscheduled_change cyc=%0d got=%h want=%h", cyc, ov, prev);
         end
         prev = ov;
      end
   end

   task automatic push(input int c);
      exp_q.push_back('{cyc: c, v: m});
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic go(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk8(input string n, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, got, want);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e, t;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = 2'd0;
      wr_data = 8'h00;
      rd_addr = 2'd0;
      m       = '0;
      m.inh   = 1'b1;
      prev    = m;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      push(cyc + 2);

      // A write alone must not touch outputs
      wr(2'd0, 8'hA5);
      t = cyc + 1000;
      push(t);
      go(t + 1);

      // Full mute/apply/release sequence
      wr(2'd0, 8'h5A);
      wr(2'd2, 8'h03);
      e = cyc + 1;
      m.busy = 1'b1; push(e); push(e + 100); push(e + 256);
      m.att = 2'd2; m.dec = 2'd2; m.slf = 2'd1; m.vp = 1'b1; m.nf = 1'b0;
      m.mix = 3'd3; m.env = 2'd1; m.vsel = 1'b1; m.vhalf = 1'b0; m.osd = 1'b1; m.vext = 1'b1;
      push(e + 257);
      m.inh = 1'b0; m.busy = 1'b0; push(e + 258);
      wr(2'd1, 8'h2B);
`ifdef SOUND_CTRL_READBACK_EN
      rd_addr = 2'd3;
      @(negedge clk);
      chk8("rd_status_mute", rd_data, 8'h91);
      go(e + 259);
      rd_addr = 2'd0;
      @(negedge clk);
      chk8("rd_active_a", rd_data, 8'h5A);
`else
      rd_addr = 2'd3;
      @(negedge clk);
      chk8("rd_tied_zero", rd_data, 8'h00);
`endif
      go(e + 260);

      // Inhibited commit from IDLE applies on the next edge, busy stays low
      e = cyc + 1;
      m.mix = 3'd4; m.env = 2'd0; m.vsel = 1'b0; m.vhalf = 1'b0; m.inh = 1'b1;
      push(e); push(e + 5);
      wr(2'd1, 8'h84);
      go(e + 6);

      // Writes during MUTE: latest shadows win, extra commits collapse into one pend
      e = cyc + 1;
      m.busy = 1'b1; push(e);
      m.att = 2'd3; m.dec = 2'd0; m.slf = 2'd0; m.vp = 1'b0; m.nf = 1'b0; m.mix = 3'd1;
      push(e + 257);
      m.inh = 1'b0; push(e + 258);
      m.inh = 1'b1; push(e + 259); push(e + 516);
      m.inh = 1'b0; m.busy = 1'b0; push(e + 517);
      wr(2'd1, 8'h2B);
      go(e + 10);
      wr(2'd0, 8'h03);
      wr(2'd1, 8'h01);
      go(e + 50);
      wr(2'd1, 8'h01);
      go(e + 520);

      // Asynchronous reset with the mute counter at 100
      e = cyc + 1;
      m.busy = 1'b1; m.inh = 1'b1; push(e);
      t = e + 155;
      m = '0; m.inh = 1'b1; push(t);
      wr(2'd1, 8'h2B);
      do begin
         @(posedge clk);
         #2;
      end while (cyc < t);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      t = cyc + 300;
      push(t);
      go(t + 1);

      // Shadows were cleared by reset: inhibited commit shows A=0, C=0
      e = cyc + 1;
      m.mix = 3'd5; push(e); push(e + 3);
      wr(2'd1, 8'h85);
      go(e + 4);

      // Commit arriving in the RELEASE cycle is pended and replayed
      e = cyc + 1;
      m.busy = 1'b1; push(e);
      m.mix = 3'd3; m.env = 2'd1; m.vsel = 1'b1; push(e + 257);
      m.inh = 1'b0; push(e + 258);
      m.inh = 1'b1; push(e + 259);
      m.mix = 3'd6; m.env = 2'd0; m.vsel = 1'b0; push(e + 516);
      m.inh = 1'b0; m.busy = 1'b0; push(e + 517);
      wr(2'd1, 8'h2B);
      go(e + 257);
      wr(2'd1, 8'h06);
      go(e + 520);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sound_reg_ctrl.md
Name: sound_reg_ctrl

Overview:
- CPU-facing control sequencer for the Interact SN76477 sound generator.
- Accepts memory-mapped writes to sound registers A, B and C into shadow registers. A write to B commits all three shadows atomically to the generator control outputs.
- Sequences every non-inhibited commit through a mute/apply/release cycle. This gives glitch-free reconfiguration and a guaranteed inhibit 1->0 edge, which retriggers the one-shot.
- Sits between the CPU bus decode and sound_generator; single clock domain (audio clock).

Parameters:
MUTE_CYCLES, 256, cycles inhibit_o is held high before new config is applied (≈10.4 us at 24.576 MHz); legal range 1..511
MUTE_W, 9, width of mute counter; must hold MUTE_CYCLES

Ports:
clk  in  1  audio clock, 24.576 MHz
rst_n  in  1  reset: asynchronous, active-low
wr_en  in  1  single-cycle write strobe
wr_addr  in  2  0=A, 1=B, 2=C, 3=ignored
wr_data  in  8  write data
rd_addr  in  2  readback select (feature only)
rd_data  out  8  readback data (feature only)
attack  out  2  A[1:0]
decay  out  2  A[3:2]
slf_sel  out  2  A[5:4]
vco_pitch  out  1  A[6]
noise_filt  out  1  A[7]
mixer_ctl  out  3  B[2:0]
envsel  out  2  B[4:3]
vco_sel  out  1  B[5]
volume_half  out  1  B[6]
inhibit_o  out  1  effective inhibit to generator
oneshot_decay  out  1  C[0]
vco_ext  out  1  C[1]
busy  out  1  FSM not IDLE or commit pending

Behaviour:
- Reset (async): all shadow and active registers = 0, except inhibit_o = 1 and active B[7] = 1. FSM = IDLE, mute counter = 0, pend = 0, busy = 0, rd_data = 0.
- Shadows: on wr_en, wr_addr 0/1/2 loads shA/shB/shC on the next edge. Shadows are written in any FSM state. Address 3 is ignored.
- Commit event: wr_en with wr_addr = 1. The commit captures the new shB value (wr_data) together with the current shA/shC, including an A/C write in the same cycle, which is impossible on a single port.
- FSM states: IDLE, MUTE, APPLY, RELEASE.
- IDLE, commit (or pend set):
  - if committed B[7] = 1: load active A/B/C in the same edge; inhibit_o = 1; stay IDLE; clear pend.
  - else: inhibit_o <= 1; counter <= MUTE_CYCLES-1; -> MUTE; clear pend.
- MUTE: counter decrements each cycle; at 0 -> APPLY.
- APPLY: load active A/B/C from shadows (one cycle) -> RELEASE.
- RELEASE: inhibit_o <= 0 -> IDLE.
- Total latency, commit edge to inhibit_o low: MUTE_CYCLES+2 cycles. Config outputs change exactly 1 cycle before inhibit_o falls.
- Commit while not IDLE: sets pend. The sequence in flight completes using shadow values as they stand at APPLY, so the latest writes win. Pending commit then starts on the cycle after RELEASE. Multiple commits while busy collapse into one pend.
- A commit in the RELEASE cycle is pended, not lost.
- busy = (state != IDLE) | pend.
- Outputs change only via the commit paths above. A/C writes alone never alter outputs.
- rst_n asserted mid-sequence: immediate return to reset values; pend cleared.

Optional Feature:
SOUND_CTRL_READBACK_EN
- Defined: rd_data registered, 1-cycle latency.
  - addr0 = active A, addr1 = active B, addr2 = {6'b0, active C[1:0]}.
  - addr3 = {busy, pend, state[1:0], 3'b0, inhibit_o}.
- Undefined: rd_data tied 0; no readback logic or extra flops.

Test Plan:
- Reset: after rst_n release, inhibit_o=1, mixer_ctl=0, busy=0; write A=8'hA5 only -> outputs unchanged after 1000 cycles.
- Write A=8'h5A, C=8'h03, then B=8'h2B (inhibit 0): inhibit_o stays 1; attack=2, decay=2, slf_sel=1, mixer_ctl=3, envsel=1, vco_sel=1, oneshot_decay=1 appear at cycle 257; inhibit_o=0 at cycle 258 after commit; busy low at cycle 258.
- Write B=8'h84 (inhibit 1) from IDLE: next edge mixer_ctl=4, inhibit_o=1, busy never asserts.
- During MUTE write A=8'h03, then B=8'h01: first sequence applies attack=3 at its APPLY; second sequence starts the cycle after RELEASE; inhibit_o pulses high again for 258 cycles; mixer_ctl=1 final.
- Assert rst_n low at counter=100 in MUTE: all outputs return to reset values asynchronously; no release occurs after deassert.
- With SOUND_CTRL_READBACK_EN: rd_addr=3 during MUTE -> rd_data[7]=1, rd_data[5:4]=MUTE encoding, rd_data[0]=1; rd_addr=0 after commit -> 8'h5A one cycle later.
